spi_txn_sched: RTL and testbench

SPI_TXN_SCHED -- requirements
Module: spi_txn_sched

---
 rtl/spi_txn_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_txn_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sched.sv
`default_nettype none
// ============================================================================
//  Module      : spi_txn_sched
//  Description : Two-requester round-robin scheduler in front of a single SPI
//                main. Grants one requester at a time, configures the SPI
//                mode for one cycle, streams the requested number of bytes,
//                guards the transfer with a watchdog and enforces an idle gap
//                with chip-select released between transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_sched #(
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    // requester side
    input  logic [1:0]           i_req,
    input  logic [3:0]           i_req_mode,
    input  logic [2*LEN_W-1:0]   i_req_len,
    input  logic [15:0]          i_req_tx_byte,
    output logic [1:0]           o_grant,
    output logic [1:0]           o_byte_ack,
    output logic [1:0]           o_rx_valid,
    output logic [7:0]           o_rx_byte,
    output logic [1:0]           o_done,
    output logic [1:0]           o_err,
    output logic                 o_busy,
    // SPI main side
    output logic                 o_spi_com_start,
    output logic                 o_spi_mode_sel,
    output logic [1:0]           o_spi_mode,
    output logic [7:0]           o_spi_tx_byte,
    input  logic                 i_spi_tx_done,
    input  logic                 i_spi_rx_done,
    input  logic [7:0]           i_spi_rx_byte
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CFG  = 2'd1;
    localparam logic [1:0] c_ST_XFER = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam int c_WD_W  = $clog2(TIMEOUT + 1);
    localparam int c_GAP_W = $clog2(GAP_CYC + 1);

    // Watchdog fires when the count that is about to be reached equals TIMEOUT,
    // so the error pulse lands exactly TIMEOUT cycles after XFER entry.
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);
    localparam logic [LEN_W-1:0]   c_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]   c_LEN_ZERO = '0;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         r_grant;
    logic               r_rr_last;      // index of the requester granted last
    logic [LEN_W-1:0]   r_rem;          // bytes still to be received
    logic [c_WD_W-1:0]  r_wdog;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_tx_done_dly;
    logic               r_rx_done_dly;
    logic [1:0]         r_byte_ack;
    logic [1:0]         r_rx_valid;
    logic [7:0]         r_rx_byte;
    logic [1:0]         r_done;
    logic [1:0]         r_err;
    logic               r_com_start;
    logic               r_mode_sel;
    logic [1:0]         r_spi_mode;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_pick1;
    logic [1:0]         w_win;
    logic [1:0]         w_win_mode;
    logic [LEN_W-1:0]   w_win_len;
    logic               w_tx_rise;
    logic               w_rx_rise;
    logic [7:0]         w_tx_byte;

    // Round-robin pick: requester 1 wins when alone, or on a tie when
    // requester 0 was the previous owner.
    always_comb begin
        w_pick1    = i_req[1] & (~i_req[0] | ~r_rr_last);
        w_win      = w_pick1 ? 2'b10 : 2'b01;
        w_win_mode = w_pick1 ? i_req_mode[3:2] : i_req_mode[1:0];
        w_win_len  = w_pick1 ? i_req_len[2*LEN_W-1:LEN_W] : i_req_len[LEN_W-1:0];
    end

    // Byte-done events are 0->1 transitions against the registered copies.
    always_comb begin
        w_tx_rise = i_spi_tx_done & ~r_tx_done_dly;
        w_rx_rise = i_spi_rx_done & ~r_rx_done_dly;
    end

    // TX byte follows the current owner's byte with no register stage.
    always_comb begin
        w_tx_byte = 8'h00;
        if (r_grant[0]) begin
            w_tx_byte = i_req_tx_byte[7:0];
        end else if (r_grant[1]) begin
            w_tx_byte = i_req_tx_byte[15:8];
        end
    end

    // Scheduler state machine with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= 2'b00;
            r_rr_last     <= 1'b1;
            r_rem         <= '0;
            r_wdog        <= '0;
            r_gap_cnt     <= '0;
            r_tx_done_dly <= 1'b0;
            r_rx_done_dly <= 1'b0;
            r_byte_ack    <= 2'b00;
            r_rx_valid    <= 2'b00;
            r_rx_byte     <= 8'h00;
            r_done        <= 2'b00;
            r_err         <= 2'b00;
            r_com_start   <= 1'b0;
            r_mode_sel    <= 1'b0;
            r_spi_mode    <= 2'b00;
        end else begin
            r_tx_done_dly <= i_spi_tx_done;
            r_rx_done_dly <= i_spi_rx_done;

            // single-cycle pulses default low
            r_byte_ack <= 2'b00;
            r_rx_valid <= 2'b00;
            r_done     <= 2'b00;
            r_err      <= 2'b00;

            case (r_state)
                c_ST_IDLE: begin
                    if (|i_req) begin
                        r_grant    <= w_win;
                        r_rem      <= w_win_len;
                        r_spi_mode <= w_win_mode;
                        r_mode_sel <= 1'b1;
                        r_state    <= c_ST_CFG;
                    end
                end

                c_ST_CFG: begin
                    r_mode_sel <= 1'b0;
                    r_wdog     <= '0;
                    r_gap_cnt  <= '0;
                    if (r_rem != c_LEN_ZERO) begin
                        r_com_start <= 1'b1;
                        r_state     <= c_ST_XFER;
                    end else begin
                        // empty transaction completes without touching the bus
                        r_done  <= r_grant;
                        r_state <= c_ST_GAP;
                    end
                end

                c_ST_XFER: begin
                    if (w_tx_rise) begin
                        r_byte_ack <= r_grant;
                    end
                    if (w_rx_rise) begin
                        r_rx_byte  <= i_spi_rx_byte;
                        r_rx_valid <= r_grant;
                        r_rem      <= r_rem - c_LEN_ONE;
                        r_wdog     <= '0;
                        if (r_rem == c_LEN_ONE) begin
                            r_com_start <= 1'b0;
                            r_done      <= r_grant;
                            r_gap_cnt   <= '0;
                            r_state     <= c_ST_GAP;
                        end
                    end else if (r_wdog == c_WD_LAST) begin
                        r_com_start <= 1'b0;
                        r_err       <= r_grant;
                        r_gap_cnt   <= '0;
                        r_state     <= c_ST_GAP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                c_ST_GAP: begin
                    // owner keeps the grant until the gap has elapsed
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_rr_last <= r_grant[1];
                        r_grant   <= 2'b00;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign o_grant         = r_grant;
    assign o_byte_ack      = r_byte_ack;
    assign o_rx_valid      = r_rx_valid;
    assign o_rx_byte       = r_rx_byte;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_busy          = (r_state != c_ST_IDLE);
    assign o_spi_com_start = r_com_start;
    assign o_spi_mode_sel  = r_mode_sel;
    assign o_spi_mode      = r_spi_mode;
    assign o_spi_tx_byte   = w_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_txn_sched
//  Description : Directed self-checking bench for spi_txn_sched with a
//                loopback SPI main model and a cycle monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sched;

    localparam int LEN_W   = 4;
    localparam int GAP_CYC = 2;
    localparam int TIMEOUT = 64;

    logic               i_clk;
    logic               i_rst;
    logic [1:0]         i_req;
    logic [3:0]         i_req_mode;
    logic [2*LEN_W-1:0] i_req_len;
    logic [15:0]        i_req_tx_byte;
    logic [1:0]         o_grant;
    logic [1:0]         o_byte_ack;
    logic [1:0]         o_rx_valid;
    logic [7:0]         o_rx_byte;
    logic [1:0]         o_done;
    logic [1:0]         o_err;
    logic               o_busy;
    logic               o_spi_com_start;
    logic               o_spi_mode_sel;
    logic [1:0]         o_spi_mode;
    logic [7:0]         o_spi_tx_byte;
    logic               i_spi_tx_done;
    logic               i_spi_rx_done;
    logic [7:0]         i_spi_rx_byte;

    spi_txn_sched #(
        .LEN_W   (LEN_W),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req           (i_req),
        .i_req_mode      (i_req_mode),
        .i_req_len       (i_req_len),
        .i_req_tx_byte   (i_req_tx_byte),
        .o_grant         (o_grant),
        .o_byte_ack      (o_byte_ack),
        .o_rx_valid      (o_rx_valid),
        .o_rx_byte       (o_rx_byte),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_busy          (o_busy),
        .o_spi_com_start (o_spi_com_start),
        .o_spi_mode_sel  (o_spi_mode_sel),
        .o_spi_mode      (o_spi_mode),
        .o_spi_tx_byte   (o_spi_tx_byte),
        .i_spi_tx_done   (i_spi_tx_done),
        .i_spi_rx_done   (i_spi_rx_done),
        .i_spi_rx_byte   (i_spi_rx_byte)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Requester byte tables: each ack advances to the next table entry
    // ------------------------------------------------------------------
    logic [7:0] tab0 [0:7];
    logic [7:0] tab1 [0:7];
    int         base0 = 0;
    int         base1 = 0;
    logic [2:0] idx0;
    logic [2:0] idx1;

    // ------------------------------------------------------------------
    // Monitor state (written only by the monitor)
    // ------------------------------------------------------------------
    int         cyc        = 0;
    int         ack0       = 0;
    int         ack1       = 0;
    int         done0      = 0;
    int         done1      = 0;
    int         err0       = 0;
    int         err1       = 0;
    int         rxv_cnt    = 0;
    int         com_hi_cnt = 0;
    int         msel_cnt   = 0;
    int         g10_cnt    = 0;
    int         onehot_bad = 0;
    int         busy_bad   = 0;
    int         low_run    = 0;
    int         com_rise_cyc = 0;
    int         err_cyc    = 0;
    logic       com_at_err = 1'b0;
    logic       com_prev   = 1'b0;
    logic [1:0] grant_prev = 2'b00;
    logic [7:0] rxq    [$];
    logic [1:0] grantq [$];
    logic [1:0] modeq  [$];
    int         lowq   [$];

    assign idx0 = 3'(ack0 - base0);
    assign idx1 = 3'(ack1 - base1);
    assign i_req_tx_byte = {tab1[idx1], tab0[idx0]};

    // Cycle monitor sampling 1 time unit after each rising edge.
    always begin
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_rx_valid != 2'b00) begin
            rxq.push_back(o_rx_byte);
            rxv_cnt++;
        end
        if (o_byte_ack[0]) ack0++;
        if (o_byte_ack[1]) ack1++;
        if (o_done[0]) done0++;
        if (o_done[1]) done1++;
        if (o_err[0]) err0++;
        if (o_err[1]) err1++;
        if (o_err != 2'b00) begin
            err_cyc    = cyc;
            com_at_err = o_spi_com_start;
        end
        if (o_spi_com_start && !com_prev) begin
            com_rise_cyc = cyc;
            lowq.push_back(low_run);
            low_run = 0;
        end
        if (!o_spi_com_start) low_run++;
        if (o_spi_com_start) com_hi_cnt++;
        if (o_grant != 2'b00 && grant_prev == 2'b00) grantq.push_back(o_grant);
        if (o_spi_mode_sel) begin
            msel_cnt++;
            modeq.push_back(o_spi_mode);
        end
        if (o_grant == 2'b10) g10_cnt++;
        if ($countones(o_grant) > 1 || $countones(o_done) > 1 || $countones(o_err) > 1 ||
            $countones(o_rx_valid) > 1 || $countones(o_byte_ack) > 1) onehot_bad++;
        if (o_busy != (o_grant != 2'b00)) busy_bad++;
        com_prev   = o_spi_com_start;
        grant_prev = o_grant;
    end

    // ------------------------------------------------------------------
    // SPI main model: loops MOSI back to MISO while com_start is high
    // ------------------------------------------------------------------
    logic rx_en = 1'b1;

    initial begin : spi_model
        logic [7:0] cap;
        i_spi_tx_done = 1'b0;
        i_spi_rx_done = 1'b0;
        i_spi_rx_byte = 8'h00;
        forever begin
            @(negedge i_clk);
            if (o_spi_com_start) begin
                repeat (2) @(negedge i_clk);
                cap = o_spi_tx_byte;
                i_spi_tx_done = 1'b1;
                repeat (2) @(negedge i_clk);
                i_spi_tx_done = 1'b0;
                if (rx_en) begin
                    i_spi_rx_byte = cap;
                    i_spi_rx_done = 1'b1;
                    repeat (2) @(negedge i_clk);
                    i_spi_rx_done = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic wait_grant(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge i_clk);
            #2;
            if (o_grant[n]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 500; i++) begin
            if (!o_busy) break;
            @(posedge i_clk);
            #2;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic run_txn(input int n, input string tag);
        logic ok;
        i_req[n] = 1'b1;
        wait_grant(n, ok);
        check({tag, "_grant"}, 32'(ok), 32'd1);
        i_req[n] = 1'b0;
        wait_idle({tag, "_idle"});
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : main
        int s_done0, s_done1, s_err0, s_rxv, s_com, s_g10, s_ack0, s_msel;
        int r0, g0, l0, m0;
        logic ok;

        i_rst      = 1'b1;
        i_req      = 2'b00;
        i_req_mode = 4'h0;
        i_req_len  = '0;
        for (int i = 0; i < 8; i++) begin
            tab0[i] = 8'h00;
            tab1[i] = 8'h00;
        end

        // ---- reset state ----
        tick(3);
        check("rst_outputs", 32'({o_grant, o_byte_ack, o_rx_valid, o_done, o_err, o_busy,
                                  o_spi_com_start, o_spi_mode_sel, o_spi_mode, o_rx_byte}), 32'd0);
        check("rst_tx_byte", 32'(o_spi_tx_byte), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        tick(3);

        // ---- single request, 3 bytes looped back ----
        tab0[0] = 8'hA5; tab0[1] = 8'h3C; tab0[2] = 8'hFF;
        base0 = ack0;
        i_req_mode[1:0] = 2'd0;
        i_req_len[3:0]  = 4'd3;
        s_done0 = done0; s_rxv = rxv_cnt; s_g10 = g10_cnt; s_ack0 = ack0; s_err0 = err0;
        r0 = rxq.size();
        run_txn(0, "single");
        check("single_rxv_cnt", 32'(rxv_cnt - s_rxv), 32'd3);
        check("single_rx0", (rxq.size() > r0)     ? 32'(rxq[r0])     : 32'hDEAD, 32'hA5);
        check("single_rx1", (rxq.size() > r0 + 1) ? 32'(rxq[r0 + 1]) : 32'hDEAD, 32'h3C);
        check("single_rx2", (rxq.size() > r0 + 2) ? 32'(rxq[r0 + 2]) : 32'hDEAD, 32'hFF);
        check("single_done", 32'(done0 - s_done0), 32'd1);
        check("single_acks", 32'(ack0 - s_ack0), 32'd3);
        check("single_grant10", 32'(g10_cnt - s_g10), 32'd0);
        check("single_err", 32'(err0 - s_err0), 32'd0);
        tick(5);

        // ---- zero-length request on requester 1 ----
        i_req_mode[3:2] = 2'd2;
        i_req_len[7:4]  = 4'd0;
        s_done1 = done1; s_rxv = rxv_cnt; s_com = com_hi_cnt;
        run_txn(1, "len0");
        check("len0_done1", 32'(done1 - s_done1), 32'd1);
        check("len0_com_start", 32'(com_hi_cnt - s_com), 32'd0);
        check("len0_rxv", 32'(rxv_cnt - s_rxv), 32'd0);
        tick(5);

        // ---- both requesting, alternating grants ----
        tab0[0] = 8'h81; tab0[1] = 8'h82;
        tab1[0] = 8'h91; tab1[1] = 8'h92;
        base0 = ack0; base1 = ack1;
        i_req_mode = 4'h0;
        i_req_len  = {4'd1, 4'd1};
        g0 = grantq.size(); r0 = rxq.size(); l0 = lowq.size();
        s_done0 = done0; s_done1 = done1;
        i_req = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (grantq.size() >= g0 + 4) begin
                ok = 1'b1;
                break;
            end
        end
        i_req = 2'b00;
        check("rr_four_grants", 32'(ok), 32'd1);
        wait_idle("rr_idle");
        check("rr_grant_count", 32'(grantq.size() - g0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d", k),
                  (grantq.size() > g0 + k) ? 32'(grantq[g0 + k]) : 32'hDEAD,
                  (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        check("rr_rx0", (rxq.size() > r0)     ? 32'(rxq[r0])     : 32'hDEAD, 32'h81);
        check("rr_rx1", (rxq.size() > r0 + 1) ? 32'(rxq[r0 + 1]) : 32'hDEAD, 32'h91);
        check("rr_rx2", (rxq.size() > r0 + 2) ? 32'(rxq[r0 + 2]) : 32'hDEAD, 32'h82);
        check("rr_rx3", (rxq.size() > r0 + 3) ? 32'(rxq[r0 + 3]) : 32'hDEAD, 32'h92);
        check("rr_done0", 32'(done0 - s_done0), 32'd2);
        check("rr_done1", 32'(done1 - s_done1), 32'd2);
        // com_start low run between transfers: GAP_CYC gap + IDLE + CFG
        for (int k = 1; k < 4; k++) begin
            check($sformatf("rr_low_run%0d", k),
                  (lowq.size() > l0 + k) ? 32'(lowq[l0 + k]) : 32'hDEAD,
                  32'(GAP_CYC + 2));
        end
        tick(5);

        // ---- mode 1 request followed by mode 3 request ----
        i_req_mode = 4'b0111;
        i_req_len  = {4'd1, 4'd1};
        m0 = modeq.size(); s_msel = msel_cnt;
        run_txn(1, "mode1");
        run_txn(0, "mode3");
        check("mode_sel_cycles", 32'(msel_cnt - s_msel), 32'd2);
        check("mode_first",  (modeq.size() > m0)     ? 32'(modeq[m0])     : 32'hDEAD, 32'd1);
        check("mode_second", (modeq.size() > m0 + 1) ? 32'(modeq[m0 + 1]) : 32'hDEAD, 32'd3);
        tick(5);

        // ---- watchdog timeout with rx_done held low ----
        rx_en = 1'b0;
        i_req_mode[1:0] = 2'd0;
        i_req_len[3:0]  = 4'd2;
        s_done0 = done0; s_err0 = err0;
        run_txn(0, "tmo");
        check("tmo_err", 32'(err0 - s_err0), 32'd1);
        check("tmo_no_done", 32'(done0 - s_done0), 32'd0);
        check("tmo_latency", 32'(err_cyc - com_rise_cyc), 32'(TIMEOUT));
        check("tmo_com_low", 32'(com_at_err), 32'd0);
        tick(20);
        rx_en = 1'b1;
        tick(5);

        // ---- reset during byte 2 of a 4-byte transfer ----
        tab0[0] = 8'h11; tab0[1] = 8'h22; tab0[2] = 8'h33; tab0[3] = 8'h44;
        base0 = ack0;
        i_req_mode[1:0] = 2'd2;
        i_req_len[3:0]  = 4'd4;
        s_done0 = done0; s_err0 = err0; s_rxv = rxv_cnt;
        i_req[0] = 1'b1;
        wait_grant(0, ok);
        check("rst_mid_grant", 32'(ok), 32'd1);
        i_req[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (rxv_cnt > s_rxv) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_mid_byte1", 32'(ok), 32'd1);
        check("rst_mid_xfer", 32'(o_spi_com_start), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        tick(1);
        check("rst_mid_outputs", 32'({o_grant, o_byte_ack, o_rx_valid, o_done, o_err, o_busy,
                                      o_spi_com_start, o_spi_mode_sel, o_spi_mode, o_rx_byte}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        tick(20);
        check("rst_mid_no_done", 32'(done0 - s_done0), 32'd0);
        check("rst_mid_no_err", 32'(err0 - s_err0), 32'd0);
        // pointer back at 1 so requester 0 wins the tie
        i_req_len = {4'd1, 4'd1};
        i_req = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (o_grant != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        i_req = 2'b00;
        check("rst_rr_grant", 32'(o_grant), 32'd1);
        wait_idle("rst_rr_idle");
        tick(5);

        // ---- whole-run invariants ----
        check("onehot_outputs", 32'(onehot_bad), 32'd0);
        check("busy_vs_grant", 32'(busy_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
